// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: widths, NOP, FSM state encodings and the IF/ID bundle
// shared by the fetch stage, its hold buffer and the imem interface.
package fetch_stage_pkg;

  localparam int PC_WIDTH = 32;
  localparam int IWIDTH   = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [IWIDTH-1:0]   inst_t;

  localparam inst_t NOP = '0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;
  localparam state_t ST_DROP  = 2'd3;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
    logic  valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory req/ack handshake between the
// fetch stage (master) and instruction memory (slave).
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  req;
  pc_t   addr;
  logic  ack;
  inst_t inst;

  modport master (
    output req,
    output addr,
    input  ack,
    input  inst
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output inst
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {pc, inst, valid} buffer that parks a memory
// response arriving while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  logic   pop,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    unique case (1'b1)
      clear:   ent_d = '0;
      load:    ent_d = din;
      pop:     ent_d.valid = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign dout = ent_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch FSM, fetch PC and IF/ID register over a req/ack imem.
// Define FETCH_REDIRECT_REG_EN to register the redirect inputs first.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter pc_t RESET_PC = '0,
  parameter pc_t PC_INC   = pc_t'(4)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_change_pc,
  input  pc_t           i_target_pc,
  input  logic          i_stall,
  fetch_stage_if.master imem,
  output pc_t           o_pc,
  output inst_t         o_inst,
  output logic          o_valid
);

  state_t state_q, state_d;
  pc_t    fetch_pc_q, fetch_pc_d;
  pc_t    drop_addr_q, drop_addr_d;
  if_id_t ifid_q, ifid_d;
  if_id_t hb_din, hb_q;
  logic   hb_load, hb_clear, hb_pop;
  logic   chg, kill, stall_eff;
  pc_t    tgt;

`ifdef FETCH_REDIRECT_REG_EN
  logic chg_q, chg_d;
  pc_t  tgt_q, tgt_d;

  always_comb begin
    chg_d = i_change_pc;
    tgt_d = i_target_pc;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      chg_q <= 1'b0;
      tgt_q <= RESET_PC;
    end else begin
      chg_q <= chg_d;
      tgt_q <= tgt_d;
    end
  end

  // the fetch completing while the redirect is in flight is wrong-path
  assign chg  = chg_q;
  assign tgt  = tgt_q;
  assign kill = i_change_pc;
`else
  assign chg  = i_change_pc;
  assign tgt  = i_target_pc;
  assign kill = 1'b0;
`endif

  assign stall_eff = i_stall & ifid_q.valid;

  assign hb_din = '{
    pc:    fetch_pc_q,
    inst:  imem.inst,
    valid: 1'b1
  };

  fetch_hold_buf u_hold (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (hb_load),
    .clear (hb_clear),
    .pop   (hb_pop),
    .din   (hb_din),
    .dout  (hb_q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (chg) begin
          state_d = imem.ack ? ST_FETCH : ST_DROP;
        end else if (imem.ack && stall_eff) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (chg || !i_stall) begin
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem.ack) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem.req    = 1'b0;
    imem.addr   = fetch_pc_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    ifid_d      = ifid_q;
    hb_load     = 1'b0;
    hb_clear    = 1'b0;
    hb_pop      = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem.req = 1'b1;
        if (chg) begin
          ifid_d.valid = 1'b0;
          hb_clear     = 1'b1;
          fetch_pc_d   = tgt;
          drop_addr_d  = fetch_pc_q;
        end else if (imem.ack) begin
          if (stall_eff) begin
            hb_load = 1'b1;
          end else begin
            ifid_d     = hb_din;
            fetch_pc_d = fetch_pc_q + PC_INC;
          end
        end else if (!stall_eff) begin
          ifid_d.valid = 1'b0;
        end
      end
      ST_HOLD: begin
        if (chg) begin
          ifid_d.valid = 1'b0;
          hb_clear     = 1'b1;
          fetch_pc_d   = tgt;
        end else if (!i_stall) begin
          ifid_d     = hb_q;
          hb_pop     = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INC;
        end
      end
      ST_DROP: begin
        // keep the old request on the bus until its response is swallowed
        imem.req     = 1'b1;
        imem.addr    = drop_addr_q;
        ifid_d.valid = 1'b0;
        if (chg) begin
          fetch_pc_d = tgt;
        end
      end
      default: ;
    endcase
    if (kill) begin
      ifid_d.valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      ifid_q      <= '{pc: RESET_PC, inst: NOP, valid: 1'b0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      ifid_q      <= ifid_d;
    end
  end

  assign o_pc    = ifid_q.pc;
  assign o_inst  = ifid_q.inst;
  assign o_valid = ifid_q.valid;

endmodule
